avmm_burst_agent: RTL and testbench
===================================

# avmm_burst_agent

Avalon-MM burst-capable agent backed by on-chip RAM. It is the responder end of the burst host interface that packet-capture hosts use. Read bursts return data with readdatavalid, write bursts accept beats under waitrequest backpressure, and a throttle input injects stalls. It serves as the packet-buffer memory in front of the capture read host and as a stand-in for SDRAM in capture simulations.

## Interface
Parameters:
- DEPTH_LOG2, 10: RAM depth in 32-bit words (1024).
- MAX_BURST, 256: largest legal burstcount.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- avs_address  in  32  byte address; word index = avs_address[DEPTH_LOG2+1:2]; bits [1:0] ignored.
- avs_read  in  1  read command.
- avs_write  in  1  write beat.
- avs_writedata  in  32  write data.
- avs_burstcount  in  16  beats in burst; sampled on the command or first-beat cycle only.
- avs_waitrequest  out  1  registered; 1 = command/beat not accepted.
- avs_readdata  out  32  read data.
- avs_readdatavalid  out  1  one pulse per returned word.
- throttle  in  1  1 = force waitrequest high in the cycle after it is asserted (registered).
- err_clr  in  1  clears err.
- err  out  1  sticky protocol-error flag.

## Operation
- Accept rule: a command or beat is taken in any cycle where (read or write) = 1 and waitrequest = 0.
- States: IDLE, RD, WR.
- IDLE:
  - Read accepted: latch word index and N; enter RD.
  - Write accepted: write beat 0 to RAM at the index; latch N.
    - N = 1: stay in IDLE.
    - Otherwise: enter WR with remaining = N-1.
- Burstcount legality:
  - N = 0 is treated as 1 and sets err.
  - N > MAX_BURST is clamped to MAX_BURST and sets err.
- RD:
  - waitrequest = 1 for the whole burst.
  - RAM read is registered and the output is registered, so the word for address k appears 2 cycles after it is issued.
  - Addresses increment by 1 per cycle and wrap modulo 2^DEPTH_LOG2.
  - Returns to IDLE after the last word is issued.
- WR:
  - Each accepted beat writes the next sequential word (with wrap) and decrements remaining.
  - The host may idle (write = 0) between beats indefinitely.
  - Reaching remaining = 0 returns to IDLE.
  - burstcount and address on non-first beats are ignored.
- Protocol errors:
  - read and write both high in IDLE: the write is taken, the read is ignored, err is set.
  - read asserted in WR: ignored, err is set.
- throttle:
  - Forces waitrequest = 1 in IDLE and WR.
  - Never pauses read data already in flight.
  - In RD, waitrequest is already 1.
- err:
  - Set has priority over err_clr in the same cycle.
  - Cleared only by err_clr or reset.
- RAM contents are not cleared by reset.

## Timing
- Reset values: waitrequest = 1, readdatavalid = 0, readdata = 0, err = 0, state = IDLE.
- waitrequest drops to 0 on the first clock edge with reset = 1, unless throttle = 1.
- Read, accepted at cycle T with N beats:
  - waitrequest = 1 from T+1.
  - readdatavalid = 1 for cycles T+2 through T+1+N, back-to-back with no gaps.
  - waitrequest returns to 0 at T+2+N, so the next command can be accepted at T+2+N.
- Write: a beat accepted at cycle T is readable by a read accepted at T+1 or later (no hazard; a read issued at T+1 returns the new data at T+3).
- Single-beat write accepted at T: the agent accepts a new command at T+1, so there is no bubble.
- throttle asserted at T gives waitrequest = 1 at T+1. Deasserted at T gives waitrequest = 0 at T+1, provided the state is not RD.
- Reset low mid-burst, sampled at edge E:
  - At E: state = IDLE, readdatavalid = 0, remaining beats discarded.
  - Partially written words remain in RAM.
- readdata holds its last value when readdatavalid = 0.
- Widths:
  - Beat counter is 16 bits.
  - Word index is DEPTH_LOG2 bits and wraps naturally.

## Test plan
- Write 4 beats 0xA0..0xA3 at 0x100, then read burst N = 4 at 0x100: readdatavalid at T+2..T+5 with 0xA0..0xA3; waitrequest low at T+6.
- Write N = 3 at word 1023 (0x0FFC): data lands in words 1023, 0, 1. A read N = 3 at 0x0FFC returns the same data in order.
- Write burst N = 4 with 2-cycle gaps between beats, plus throttle pulsed for 3 cycles mid-burst: exactly 4 words written; the beat presented during throttle is held until waitrequest = 0.
- Read with N = 0, then N = 300: 1 and 256 words returned respectively; err = 1 after each; err_clr returns err to 0.
- read and write asserted together in IDLE: write performed, no readdatavalid, err = 1. A read asserted during a WR burst is ignored and sets err.
- Reset pulsed at the 3rd readdatavalid of an N = 8 read: readdatavalid = 0 from that edge, waitrequest = 1 during reset, 0 one edge after release; RAM data intact on a re-read.

Source files
------------

// File: rtl/avmm_burst_agent.sv
// Avalon-MM burst agent backed by a single-port-per-direction on-chip RAM.
// Read bursts stream words with readdatavalid; write bursts take beats under waitrequest.
module avmm_burst_agent #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned MAX_BURST  = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic [15:0] avs_burstcount,
  output logic        avs_waitrequest,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  input  logic        throttle,
  input  logic        err_clr,
  output logic        err
);

  localparam int unsigned DW    = 32;
  localparam int unsigned BCW   = 16;
  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [BCW-1:0]  rem_q, rem_d;
  logic            waitrequest_q, waitrequest_d;
  logic            rvalid_q, rvalid_d;
  logic            readdatavalid_q, readdatavalid_d;
  logic [DW-1:0]   readdata_q, readdata_d;
  logic            err_q, err_d;

  logic [DW-1:0]   mem_q [DEPTH];
  logic [DW-1:0]   ram_rdata_q;

  logic            open_c;
  logic            err_set_c;
  logic            mem_we_c;
  logic            mem_re_c;
  logic [AW-1:0]   mem_waddr_c;
  logic [AW-1:0]   mem_raddr_c;
  logic [AW-1:0]   cmd_idx_c;
  logic [BCW-1:0]  cmd_n_c;
  logic            cmd_bad_c;
  logic            unused_addr_bits_c;

  assign unused_addr_bits_c = ^{avs_address[31:AW+2], avs_address[1:0]};

  // Burstcount legalisation: 0 becomes 1, oversize clamps; both flag an error.
  always_comb begin
    cmd_idx_c = avs_address[AW+1:2];
    cmd_n_c   = avs_burstcount;
    cmd_bad_c = 1'b0;
    if (avs_burstcount == '0) begin
      cmd_n_c   = BCW'(1);
      cmd_bad_c = 1'b1;
    end else if (avs_burstcount > BCW'(MAX_BURST)) begin
      cmd_n_c   = BCW'(MAX_BURST);
      cmd_bad_c = 1'b1;
    end
  end

  // Next-state, RAM control and registered-output computation.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    err_set_c   = 1'b0;
    mem_we_c    = 1'b0;
    mem_re_c    = 1'b0;
    mem_waddr_c = addr_q;
    mem_raddr_c = addr_q;
    open_c      = reset && !waitrequest_q;

    unique case (state_q)
      ST_IDLE: begin
        if (open_c && avs_write) begin
          mem_we_c    = 1'b1;
          mem_waddr_c = cmd_idx_c;
          addr_d      = cmd_idx_c + AW'(1);
          rem_d       = cmd_n_c - BCW'(1);
          err_set_c   = avs_read || cmd_bad_c;
          if (cmd_n_c != BCW'(1)) state_d = ST_WR;
        end else if (open_c && avs_read) begin
          mem_re_c    = 1'b1;
          mem_raddr_c = cmd_idx_c;
          addr_d      = cmd_idx_c + AW'(1);
          rem_d       = cmd_n_c - BCW'(1);
          err_set_c   = cmd_bad_c;
          if (cmd_n_c != BCW'(1)) state_d = ST_RD;
        end
      end
      ST_RD: begin
        mem_re_c = 1'b1;
        addr_d   = addr_q + AW'(1);
        rem_d    = rem_q - BCW'(1);
        if (rem_q == BCW'(1)) state_d = ST_IDLE;
      end
      ST_WR: begin
        if (reset && avs_read) err_set_c = 1'b1;
        if (open_c && avs_write) begin
          mem_we_c = 1'b1;
          addr_d   = addr_q + AW'(1);
          rem_d    = rem_q - BCW'(1);
          if (rem_q == BCW'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rvalid_d        = mem_re_c;
    readdatavalid_d = rvalid_q;
    readdata_d      = rvalid_q ? ram_rdata_q : readdata_q;
    // Busy until the last returned word has left the output register.
    waitrequest_d   = throttle || (state_d == ST_RD) || rvalid_d || readdatavalid_d;
    err_d           = err_set_c ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      waitrequest_q   <= 1'b1;
      rvalid_q        <= 1'b0;
      readdatavalid_q <= 1'b0;
      readdata_q      <= '0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      waitrequest_q   <= waitrequest_d;
      rvalid_q        <= rvalid_d;
      readdatavalid_q <= readdatavalid_d;
      readdata_q      <= readdata_d;
      err_q           <= err_d;
    end
  end

  // RAM array is intentionally not reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[mem_waddr_c] <= avs_writedata;
    if (mem_re_c) ram_rdata_q <= mem_q[mem_raddr_c];
  end

  assign avs_waitrequest   = waitrequest_q;
  assign avs_readdata      = readdata_q;
  assign avs_readdatavalid = readdatavalid_q;
  assign err               = err_q;

endmodule

// File: tb/tb_avmm_burst_agent.sv
// Scoreboard bench for avmm_burst_agent: a host driver issues bursts against a
// word-array memory model and a monitor checks every returned word and its cycle.
module tb_avmm_burst_agent;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [15:0] avs_burstcount = 16'd1;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        throttle = 1'b0;
  logic        err_clr = 1'b0;
  logic        err;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned mem_m [1024];
  int unsigned wbuf [256];
  int          nvec = 0;
  int          nfail = 0;
  int          cyc = 0;

  avmm_burst_agent #(.DEPTH_LOG2(10), .MAX_BURST(256)) dut (
    .clk               (clk),
    .reset             (reset),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_burstcount    (avs_burstcount),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .throttle          (throttle),
    .err_clr           (err_clr),
    .err               (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every readdatavalid pulse must match the oldest expected word and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (avs_readdatavalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rdv_unexpected", 32'(avs_readdatavalid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", avs_readdata, e.data);
        chk("rd_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  function automatic int eff_n(input int bc);
    if (bc == 0) return 1;
    if (bc > 256) return 256;
    return bc;
  endfunction

  task automatic wait_accept(output bit ok);
    int g;
    g = 0;
    ok = 1'b1;
    while (avs_waitrequest !== 1'b0) begin
      @(negedge clk);
      g++;
      if (g > 3000) begin
        ok = 1'b0;
        nvec++;
        nfail++;
        $display("FAIL accept_timeout: waitrequest=%b, required 0", avs_waitrequest);
        return;
      end
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input int bc, input int gap,
                          input bit rd_gap, input bit chk_tail);
    int n;
    int idx;
    bit ok;
    n = eff_n(bc);
    idx = int'(addr[11:2]);
    for (int b = 0; b < n; b++) begin
      if (b > 0) begin
        for (int g = 0; g < gap; g++) begin
          avs_write = 1'b0;
          avs_read = rd_gap;
          @(negedge clk);
        end
      end
      avs_read = 1'b0;
      avs_write = 1'b1;
      avs_writedata = wbuf[b];
      avs_address = (b == 0) ? addr : $urandom;
      avs_burstcount = (b == 0) ? 16'(bc) : 16'($urandom);
      wait_accept(ok);
      if (!ok) begin
        avs_write = 1'b0;
        return;
      end
      mem_m[(idx + b) % 1024] = wbuf[b];
      @(negedge clk);
    end
    avs_write = 1'b0;
    if (chk_tail) chk("wr_wait_release", 32'(avs_waitrequest), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int bc, input bit chk_tail);
    int n;
    int idx;
    int t0;
    bit ok;
    exp_t e;
    n = eff_n(bc);
    idx = int'(addr[11:2]);
    avs_write = 1'b0;
    avs_read = 1'b1;
    avs_address = addr;
    avs_burstcount = 16'(bc);
    wait_accept(ok);
    if (!ok) begin
      avs_read = 1'b0;
      return;
    end
    t0 = cyc;
    for (int k = 0; k < n; k++) begin
      e.data = mem_m[(idx + k) % 1024];
      e.cyc = t0 + 2 + k;
      exp_q.push_back(e);
    end
    @(negedge clk);
    avs_read = 1'b0;
    avs_address = $urandom;
    for (int k = 0; k <= n; k++) begin
      chk("rd_wait_busy", 32'(avs_waitrequest), 32'd1);
      @(negedge clk);
    end
    if (chk_tail) chk("rd_wait_release", 32'(avs_waitrequest), 32'd0);
  endtask

  task automatic err_clear();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared", 32'(err), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int t0;
    exp_t e;

    repeat (3) @(negedge clk);
    chk("rst_wait", 32'(avs_waitrequest), 32'd1);
    chk("rst_rdv", 32'(avs_readdatavalid), 32'd0);
    chk("rst_rdata", avs_readdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("wait_after_rst", 32'(avs_waitrequest), 32'd0);

    // Fill the whole RAM so every later read has a known model value.
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < 256; b++) wbuf[b] = $urandom;
      do_write(32'(i * 1024), 256, 0, 1'b0, 1'b1);
    end

    for (int b = 0; b < 4; b++) wbuf[b] = 32'hA0 + 32'(b);
    do_write(32'h100, 4, 0, 1'b0, 1'b1);
    do_read(32'h100, 4, 1'b1);

    for (int b = 0; b < 3; b++) wbuf[b] = $urandom;
    do_write(32'h0FFC, 3, 0, 1'b0, 1'b1);
    do_read(32'h0FFC, 3, 1'b1);

    // Gapped write with a 3-cycle throttle pulse landing mid-burst.
    for (int b = 0; b < 4; b++) wbuf[b] = $urandom;
    fork
      do_write(32'h500, 4, 2, 1'b0, 1'b0);
      begin
        repeat (4) @(negedge clk);
        throttle = 1'b1;
        repeat (3) @(negedge clk);
        throttle = 1'b0;
      end
    join
    @(negedge clk);
    do_read(32'h4F8, 6, 1'b1);
    chk("err_clean", 32'(err), 32'd0);

    do_read(32'h40, 0, 1'b1);
    chk("err_bc0", 32'(err), 32'd1);
    err_clear();
    do_read(32'h40, 300, 1'b1);
    chk("err_bc300", 32'(err), 32'd1);
    err_clear();

    // Read and write together in IDLE: write wins, no data returned.
    avs_read = 1'b1;
    avs_write = 1'b1;
    avs_address = 32'h300;
    avs_burstcount = 16'd1;
    avs_writedata = $urandom;
    wait_accept(ok);
    if (ok) mem_m[32'h300 >> 2] = avs_writedata;
    @(negedge clk);
    avs_read = 1'b0;
    avs_write = 1'b0;
    chk("err_rd_wr", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
    err_clear();
    do_read(32'h300, 1, 1'b1);

    for (int b = 0; b < 3; b++) wbuf[b] = $urandom;
    do_write(32'h600, 3, 1, 1'b1, 1'b1);
    chk("err_rd_in_wr", 32'(err), 32'd1);
    err_clear();
    do_read(32'h600, 3, 1'b1);

    // Reset on the 3rd returned word of an 8-beat read.
    avs_read = 1'b1;
    avs_address = 32'h200;
    avs_burstcount = 16'd8;
    wait_accept(ok);
    t0 = cyc;
    for (int k = 0; k < 8; k++) begin
      e.data = mem_m[(32'h200 >> 2) + k];
      e.cyc = t0 + 2 + k;
      exp_q.push_back(e);
    end
    @(negedge clk);
    avs_read = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_q.delete();
    chk("rst_mid_rdv", 32'(avs_readdatavalid), 32'd0);
    chk("rst_mid_wait", 32'(avs_waitrequest), 32'd1);
    chk("rst_mid_rdata", avs_readdata, 32'd0);
    @(negedge clk);
    chk("rst_mid_rdv2", 32'(avs_readdatavalid), 32'd0);
    chk("rst_mid_wait2", 32'(avs_waitrequest), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_rel_wait", 32'(avs_waitrequest), 32'd0);
    do_read(32'h200, 8, 1'b1);

    for (int it = 0; it < 30; it++) begin
      logic [31:0] a;
      int bc;
      a = $urandom;
      bc = int'($urandom_range(1, 16));
      if ($urandom_range(0, 1) == 0) begin
        for (int b = 0; b < bc; b++) wbuf[b] = $urandom;
        do_write(a, bc, int'($urandom_range(0, 2)), 1'b0, 1'b1);
      end else begin
        do_read(a, bc, 1'b1);
      end
    end
    chk("err_final", 32'(err), 32'd0);

    repeat (5) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
